// File: rtl/cpu_pkg.sv
// Shared CPU definitions: microcode bit indices, ALU/compare/pre-ALU select enums
// and RV32I opcode constants.
package cpu_pkg;

  localparam int unsigned MC_CHECK_RS1         = 0;
  localparam int unsigned MC_CHECK_RS2         = 1;
  localparam int unsigned MC_A_SEL             = 2;   // 2 bits
  localparam int unsigned MC_B_SEL             = 4;   // 2 bits
  localparam int unsigned MC_A_TO_ALU          = 6;
  localparam int unsigned MC_B_TO_ALU          = 7;
  localparam int unsigned MC_MEM_WE            = 11;
  localparam int unsigned MC_ALU_TO_MEM_ADDR   = 12;
  localparam int unsigned MC_REG_B_TO_MEM_DATA = 13;
  localparam int unsigned MC_JUMP_IF_BRANCH    = 14;
  localparam int unsigned MC_MEM_IN_USE        = 15;
  localparam int unsigned MC_REG_WE            = 16;
  localparam int unsigned MC_UP_TO_RD          = 17;
  localparam int unsigned MC_ALU_TO_RD         = 18;
  localparam int unsigned MC_RET_TO_RD         = 19;
  localparam int unsigned MC_MEM_TO_RD         = 20;
  localparam int unsigned MC_TRUNC_UBYTE       = 21;
  localparam int unsigned MC_TRUNC_UHALF       = 22;
  localparam int unsigned MC_TRUNC_SBYTE       = 23;
  localparam int unsigned MC_TRUNC_SHALF       = 24;
  localparam int unsigned MC_ST_BYTE           = MC_TRUNC_UBYTE;
  localparam int unsigned MC_ST_HALF           = MC_TRUNC_UHALF;
  localparam int unsigned MC_ALU_OP            = 25;  // 4 bits
  localparam int unsigned MC_CMP_OP            = 29;  // 3 bits

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    CMP_NULL, CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU, CMP_TRUE
  } cmp_ops_e;

  typedef enum logic [1:0] {
    PRE_A_REG  = 2'b00,
    PRE_A_PC   = 2'b01,
    PRE_A_ZERO = 2'b10
  } pre_alu_a_e;

  typedef enum logic [1:0] {
    PRE_B_REG, PRE_B_IMM_I, PRE_B_IMM_S, PRE_B_IMM_BJ
  } pre_alu_b_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/decode_rom.sv
// Combinational RV32I decode: instruction word -> microcode word plus illegal flag.
// FENCE/SYSTEM and illegal words yield an all-zero (bubble) microcode.
module decode_rom
  import cpu_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] microcode,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_zero;
  logic       unused_fields;

  assign opcode        = inst[6:0];
  assign funct3        = inst[14:12];
  assign funct7        = inst[31:25];
  assign rd_zero       = (inst[11:7] == 5'd0);
  assign unused_fields = ^inst[24:15];

  alu_op_e    alu;
  cmp_ops_e   cmp;
  pre_alu_a_e a_sel;
  pre_alu_b_e b_sel;

  function automatic alu_op_e base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    microcode = '0;
    illegal   = 1'b0;
    alu       = ALU_ADD;
    cmp       = CMP_NULL;
    a_sel     = PRE_A_REG;
    b_sel     = PRE_B_REG;
    case (opcode)
      OPC_LUI: begin
        microcode[MC_REG_WE]   = 1'b1;
        microcode[MC_UP_TO_RD] = 1'b1;
      end
      OPC_AUIPC: begin
        a_sel                  = PRE_A_PC;
        microcode[MC_A_TO_ALU] = 1'b1;
        microcode[MC_REG_WE]   = 1'b1;
        microcode[MC_UP_TO_RD] = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        if (opcode == OPC_JAL) begin
          a_sel = PRE_A_PC;
          b_sel = PRE_B_IMM_BJ;
        end else begin
          b_sel                   = PRE_B_IMM_I;
          microcode[MC_CHECK_RS1] = 1'b1;
          illegal                 = (funct3 != 3'b000);
        end
        cmp                          = CMP_TRUE;
        microcode[MC_A_TO_ALU]       = 1'b1;
        microcode[MC_B_TO_ALU]       = 1'b1;
        microcode[MC_JUMP_IF_BRANCH] = 1'b1;
        microcode[MC_REG_WE]         = 1'b1;
        microcode[MC_RET_TO_RD]      = 1'b1;
      end
      OPC_BRANCH: begin
        a_sel                        = PRE_A_PC;
        b_sel                        = PRE_B_IMM_BJ;
        microcode[MC_CHECK_RS1]      = 1'b1;
        microcode[MC_CHECK_RS2]      = 1'b1;
        microcode[MC_A_TO_ALU]       = 1'b1;
        microcode[MC_B_TO_ALU]       = 1'b1;
        microcode[MC_JUMP_IF_BRANCH] = 1'b1;
        case (funct3)
          3'b000:  cmp = CMP_EQ;
          3'b001:  cmp = CMP_NE;
          3'b100:  cmp = CMP_LT;
          3'b101:  cmp = CMP_GE;
          3'b110:  cmp = CMP_LTU;
          3'b111:  cmp = CMP_GEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        b_sel                         = PRE_B_IMM_I;
        microcode[MC_CHECK_RS1]       = 1'b1;
        microcode[MC_A_TO_ALU]        = 1'b1;
        microcode[MC_B_TO_ALU]        = 1'b1;
        microcode[MC_ALU_TO_MEM_ADDR] = 1'b1;
        microcode[MC_MEM_IN_USE]      = 1'b1;
        microcode[MC_REG_WE]          = 1'b1;
        microcode[MC_MEM_TO_RD]       = 1'b1;
        case (funct3)
          3'b000:  microcode[MC_TRUNC_SBYTE] = 1'b1;
          3'b001:  microcode[MC_TRUNC_SHALF] = 1'b1;
          3'b010:  ;
          3'b100:  microcode[MC_TRUNC_UBYTE] = 1'b1;
          3'b101:  microcode[MC_TRUNC_UHALF] = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        b_sel                           = PRE_B_IMM_S;
        microcode[MC_CHECK_RS1]         = 1'b1;
        microcode[MC_CHECK_RS2]         = 1'b1;
        microcode[MC_A_TO_ALU]          = 1'b1;
        microcode[MC_B_TO_ALU]          = 1'b1;
        microcode[MC_MEM_WE]            = 1'b1;
        microcode[MC_ALU_TO_MEM_ADDR]   = 1'b1;
        microcode[MC_REG_B_TO_MEM_DATA] = 1'b1;
        microcode[MC_MEM_IN_USE]        = 1'b1;
        case (funct3)
          3'b000:  microcode[MC_ST_BYTE] = 1'b1;
          3'b001:  microcode[MC_ST_HALF] = 1'b1;
          3'b010:  ;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        b_sel                   = PRE_B_IMM_I;
        alu                     = base_alu(funct3);
        microcode[MC_CHECK_RS1] = 1'b1;
        microcode[MC_A_TO_ALU]  = 1'b1;
        microcode[MC_B_TO_ALU]  = 1'b1;
        microcode[MC_REG_WE]    = 1'b1;
        microcode[MC_ALU_TO_RD] = 1'b1;
        // Only shift-immediates constrain funct7; elsewhere it is immediate data.
        if (funct3 == 3'b001 && funct7 != 7'h00) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'h20)      alu     = ALU_SRA;
          else if (funct7 != 7'h00) illegal = 1'b1;
        end
      end
      OPC_OP: begin
        microcode[MC_CHECK_RS1] = 1'b1;
        microcode[MC_CHECK_RS2] = 1'b1;
        microcode[MC_A_TO_ALU]  = 1'b1;
        microcode[MC_B_TO_ALU]  = 1'b1;
        microcode[MC_REG_WE]    = 1'b1;
        microcode[MC_ALU_TO_RD] = 1'b1;
        case (funct7)
          7'h00: alu = base_alu(funct3);
          7'h20: begin
            if (funct3 == 3'b000)      alu     = ALU_SUB;
            else if (funct3 == 3'b101) alu     = ALU_SRA;
            else                       illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase

    microcode[MC_A_SEL +: 2]  = a_sel;
    microcode[MC_B_SEL +: 2]  = b_sel;
    microcode[MC_ALU_OP +: 4] = alu;
    microcode[MC_CMP_OP +: 3] = cmp;
    if (rd_zero) microcode[MC_REG_WE] = 1'b0;
    if (illegal) microcode = '0;
  end

endmodule

// File: rtl/inst_decoder.sv
// Decode stage si -> s0: post-reset fill bubbles, block bubbles, decoded-word counter.
// `INST_DECODER_ILLEGAL_TRAP_EN: illegal words set a sticky flag and halt the stage.
module inst_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned FILL_CYCLES = 2,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        inst_si,
  input  logic               block_inst,
  output logic [31:0]        microcode_s0,
  output logic [24:0]        instruction_data_s0,
  output logic               illegal_inst,
  output logic [COUNT_W-1:0] decode_count
);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_HALT} state_e;

  localparam int unsigned      FC_W      = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FILL_INIT = FC_W'(FILL_CYCLES - 1);

  state_e          state_q, state_d;
  logic [FC_W-1:0] fill_q, fill_d;
  logic [31:0]     rom_mc;
  logic            rom_illegal;
  logic [31:0]     mc_d;
  logic            count_en;
`ifdef INST_DECODER_ILLEGAL_TRAP_EN
  logic            trap;
  logic            illegal_q;
`endif

  decode_rom u_decode_rom (
    .inst      (inst_si),
    .microcode (rom_mc),
    .illegal   (rom_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      fill_q  <= FILL_INIT;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    mc_d     = '0;
    count_en = 1'b0;
`ifdef INST_DECODER_ILLEGAL_TRAP_EN
    trap     = 1'b0;
`endif
    case (state_q)
      S_FILL: begin
        if (fill_q == '0) state_d = S_RUN;
        else              fill_d  = fill_q - FC_W'(1);
      end
      S_RUN: begin
        // Block has priority: a blocked illegal word will be replayed later.
        if (!block_inst) begin
          if (rom_illegal) begin
`ifdef INST_DECODER_ILLEGAL_TRAP_EN
            trap    = 1'b1;
            state_d = S_HALT;
`endif
          end else begin
            mc_d     = rom_mc;
            count_en = |rom_mc;
          end
        end
      end
      S_HALT: ;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      microcode_s0        <= '0;
      instruction_data_s0 <= '0;
      decode_count        <= '0;
    end else begin
      microcode_s0        <= mc_d;
      instruction_data_s0 <= inst_si[31:7];
      if (count_en) decode_count <= decode_count + COUNT_W'(1);
    end
  end

`ifdef INST_DECODER_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    illegal_q <= 1'b0;
    else if (trap) illegal_q <= 1'b1;
  end
  assign illegal_inst = illegal_q;
`else
  assign illegal_inst = 1'b0;
`endif

endmodule

// File: tb/tb_inst_decoder.sv
// Self-checking bench for inst_decoder: directed vectors plus randomized words
// checked against a field-level behavioural decode model.
module tb_inst_decoder;

  localparam int unsigned FILL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_si = '0;
  logic        block_inst = 1'b0;
  logic [31:0] microcode_s0;
  logic [24:0] instruction_data_s0;
  logic        illegal_inst;
  logic [31:0] decode_count;

  inst_decoder #(.FILL_CYCLES(FILL), .COUNT_W(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .inst_si             (inst_si),
    .block_inst          (block_inst),
    .microcode_s0        (microcode_s0),
    .instruction_data_s0 (instruction_data_s0),
    .illegal_inst        (illegal_inst),
    .decode_count        (decode_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          fill_left;
  bit          halted;
  logic        exp_ill;
  logic [31:0] exp_cnt;
  logic [31:0] exp_mc;
  logic [24:0] exp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {legal, microcode}, assembled field by field from the bit map.
  function automatic logic [32:0] ref_decode(input logic [31:0] w);
    int op, f3, f7, rd;
    int rs1 = 0, rs2 = 0, asel = 0, bsel = 0, a2 = 0, b2 = 0;
    int mwe = 0, maddr = 0, mdata = 0, jmp = 0, muse = 0, rwe = 0;
    int src = 0, trunc = 0, alu = 0, cmp = 0;
    bit legal = 1'b1, bubble = 1'b0;
    int bcmp[8]   = '{1, 2, -1, -1, 3, 4, 5, 6};
    int fn_alu[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int ltr[8]    = '{3, 4, 0, -1, 1, 2, -1, -1};
    int str[8]    = '{1, 2, 0, -1, -1, -1, -1, -1};
    longint mc;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]); rd = int'(w[11:7]);
    case (op)
      'h37: begin rwe = 1; src = 1; end
      'h17: begin asel = 1; a2 = 1; rwe = 1; src = 1; end
      'h6F: begin asel = 1; bsel = 3; a2 = 1; b2 = 1; jmp = 1; cmp = 7; rwe = 1; src = 3; end
      'h67: begin legal = (f3 == 0); rs1 = 1; bsel = 1; a2 = 1; b2 = 1; jmp = 1; cmp = 7; rwe = 1; src = 3; end
      'h63: begin rs1 = 1; rs2 = 1; asel = 1; bsel = 3; a2 = 1; b2 = 1; jmp = 1; cmp = bcmp[f3]; legal = (cmp >= 0); end
      'h03: begin rs1 = 1; bsel = 1; a2 = 1; b2 = 1; maddr = 1; muse = 1; rwe = 1; src = 4; trunc = ltr[f3]; legal = (trunc >= 0); end
      'h23: begin rs1 = 1; rs2 = 1; bsel = 2; a2 = 1; b2 = 1; mwe = 1; maddr = 1; mdata = 1; muse = 1; trunc = str[f3]; legal = (trunc >= 0); end
      'h13: begin
        rs1 = 1; bsel = 1; a2 = 1; b2 = 1; rwe = 1; src = 2; alu = fn_alu[f3];
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) begin if (f7 == 'h20) alu = 7; else legal = (f7 == 0); end
      end
      'h33: begin
        rs1 = 1; rs2 = 1; a2 = 1; b2 = 1; rwe = 1; src = 2;
        if (f7 == 0) alu = fn_alu[f3];
        else if (f7 == 'h20 && f3 == 0) alu = 1;
        else if (f7 == 'h20 && f3 == 5) alu = 7;
        else legal = 1'b0;
      end
      'h0F, 'h73: bubble = 1'b1;
      default: legal = 1'b0;
    endcase
    if (rd == 0) rwe = 0;
    if (!legal || bubble) return {legal, 32'h0};
    mc = longint'(rs1) + (longint'(rs2) << 1) + (longint'(asel) << 2) + (longint'(bsel) << 4)
       + (longint'(a2) << 6) + (longint'(b2) << 7) + (longint'(mwe) << 11) + (longint'(maddr) << 12)
       + (longint'(mdata) << 13) + (longint'(jmp) << 14) + (longint'(muse) << 15) + (longint'(rwe) << 16)
       + (longint'(alu) << 25) + (longint'(cmp) << 29);
    if (src > 0)   mc += longint'(1) << (16 + src);
    if (trunc > 0) mc += longint'(1) << (20 + trunc);
    return {1'b1, mc[31:0]};
  endfunction

  function automatic logic [31:0] gen_word();
    logic [6:0]  opcs[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;
    w[6:0] = opcs[$urandom_range(0, 10)];
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic model_reset();
    fill_left = FILL; halted = 1'b0; exp_ill = 1'b0;
    exp_cnt = '0; exp_mc = '0; exp_data = '0;
  endtask

  task automatic step(input logic [31:0] w, input logic blk);
    logic [32:0] d;
    inst_si    = w;
    block_inst = blk;
    @(posedge clk); #1;
    d        = ref_decode(w);
    exp_data = w[31:7];
    if (fill_left > 0) begin
      exp_mc = '0;
      fill_left--;
    end else if (halted || blk) begin
      exp_mc = '0;
    end else if (!d[32]) begin
      exp_mc = '0;
`ifdef INST_DECODER_ILLEGAL_TRAP_EN
      halted  = 1'b1;
      exp_ill = 1'b1;
`endif
    end else begin
      exp_mc = d[31:0];
      if (exp_mc != '0) exp_cnt++;
    end
    check("microcode", microcode_s0, exp_mc);
    check("inst_data", 32'(instruction_data_s0), 32'(exp_data));
    check("illegal", 32'(illegal_inst), 32'(exp_ill));
    check("count", decode_count, exp_cnt);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mc"}, microcode_s0, 32'h0);
    check({tag, "_data"}, 32'(instruction_data_s0), 32'h0);
    check({tag, "_ill"}, 32'(illegal_inst), 32'h0);
    check({tag, "_cnt"}, decode_count, 32'h0);
  endtask

  localparam logic [31:0] ADDI = 32'h00510093;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] NOP  = 32'h00000013;

  initial begin
    logic [31:0] w;
    logic [32:0] d;
    logic [31:0] saved_cnt;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(ADDI, 1'b0);
    check("fill1_mc", microcode_s0, 32'h0);
    step(ADDI, 1'b0);
    check("fill2_mc", microcode_s0, 32'h0);
    step(ADDI, 1'b0);
    check("addi_mc", microcode_s0, 32'h000500D1);
    check("addi_data", 32'(instruction_data_s0), 32'h0000A201);
    check("addi_cnt", decode_count, 32'd1);

    step(BEQ, 1'b0);
    check("beq_mc", microcode_s0, 32'h200040F7);
    step(NOP, 1'b0);
    check("nop_mc", microcode_s0, 32'h000400D1);

    saved_cnt = decode_count;
    for (int i = 0; i < 3; i++) begin
      step(ADDI, 1'b1);
      check("blk_mc", microcode_s0, 32'h0);
      check("blk_cnt", decode_count, saved_cnt);
    end
    step(ADDI, 1'b0);
    check("unblk_mc", microcode_s0, 32'h000500D1);

    step(32'hFFFFFFFF, 1'b1);
    check("blk_illegal_flag", 32'(illegal_inst), 32'h0);
    step(ADDI, 1'b0);
    check("after_blk_illegal_mc", microcode_s0, 32'h000500D1);

    for (int i = 0; i < 300; i++) begin
      w = gen_word();
`ifdef INST_DECODER_ILLEGAL_TRAP_EN
      d = ref_decode(w);
      while (!d[32]) begin
        w = gen_word();
        d = ref_decode(w);
      end
`endif
      step(w, ($urandom_range(0, 3) == 0));
    end

    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(ADDI, 1'b0);
    step(ADDI, 1'b0);
    step(ADDI, 1'b0);
    check("refill_mc", microcode_s0, 32'h000500D1);

    step(32'hFFFFFFFF, 1'b0);
`ifdef INST_DECODER_ILLEGAL_TRAP_EN
    check("trap_flag", 32'(illegal_inst), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(ADDI, 1'b0);
      check("halt_mc", microcode_s0, 32'h0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("trap_cleared", 32'(illegal_inst), 32'h0);
`else
    check("no_trap_flag", 32'(illegal_inst), 32'h0);
    step(ADDI, 1'b0);
    check("post_illegal_mc", microcode_s0, 32'h000500D1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
